// File: rtl/alu_shift_unit.sv
// alu_shift_unit: multi-cycle shift/rotate unit on the ALU command interface.
// One bit position is shifted per clock, so an n-position operation takes
// n+1 cycles from the accept edge to the result pulse.
//
// Handshake: a command is accepted on a rising edge where o_ready is high and
// i_cmd is not NOP; o_ready then drops until the unit has delivered its result.
// o_valid is a single-cycle pulse carrying o_result, and it is never high in the
// same cycle as o_ready. o_result holds its value until the next o_valid pulse.
module alu_shift_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_cmd,
    output logic [WIDTH-1:0] o_result,
    output logic             o_valid,
    output logic             o_ready
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] CMD_NOP = 4'h0;
    localparam logic [3:0] CMD_SHL = 4'h1;
    localparam logic [3:0] CMD_SHR = 4'h2;
    localparam logic [3:0] CMD_SAR = 4'h3;
    localparam logic [3:0] CMD_ROL = 4'h4;
    localparam logic [3:0] CMD_ROR = 4'h5;

    localparam logic [SW-1:0] CNT_ONE = {{(SW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_BUSY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // state is the observable FSM state for checkers bound to this block
    state_t state;
    state_t state_next;

    logic [3:0]       op;
    logic [3:0]       op_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [SW-1:0]    cnt;
    logic [SW-1:0]    cnt_next;
    logic [WIDTH-1:0] result_next;
    logic             valid_next;
    logic             ready_next;

    logic [SW-1:0]    amt;
    logic             big;
    logic [WIDTH-1:0] load_acc;
    logic [SW-1:0]    load_cnt;
    logic [WIDTH-1:0] step;

    // Decode the operand load and effective shift count for a new command.
    // Oversized logical/arithmetic shifts collapse to their saturated value
    // immediately so they complete in a single cycle; rotates only use the
    // low bits since rotation is periodic in WIDTH.
    always_comb begin
        amt      = i_b[SW-1:0];
        big      = |i_b[WIDTH-1:SW];
        load_acc = '0;
        load_cnt = '0;
        case (i_cmd)
            CMD_SHL, CMD_SHR: begin
                load_acc = big ? '0 : i_a;
                load_cnt = big ? '0 : amt;
            end
            CMD_SAR: begin
                load_acc = big ? {WIDTH{i_a[WIDTH-1]}} : i_a;
                load_cnt = big ? '0 : amt;
            end
            CMD_ROL, CMD_ROR: begin
                load_acc = i_a;
                load_cnt = amt;
            end
            default: begin
                load_acc = '0;
                load_cnt = '0;
            end
        endcase
    end

    // One-position step of the accumulator for the latched opcode.
    always_comb begin
        step = acc;
        case (op)
            CMD_SHL: step = {acc[WIDTH-2:0], 1'b0};
            CMD_SHR: step = {1'b0, acc[WIDTH-1:1]};
            CMD_SAR: step = {acc[WIDTH-1], acc[WIDTH-1:1]};
            CMD_ROL: step = {acc[WIDTH-2:0], acc[WIDTH-1]};
            CMD_ROR: step = {acc[0], acc[WIDTH-1:1]};
            default: step = acc;
        endcase
    end

    // Next-state and next-output logic for the INIT/IDLE/BUSY/DONE sequence.
    always_comb begin
        state_next  = state;
        op_next     = op;
        acc_next    = acc;
        cnt_next    = cnt;
        result_next = o_result;
        valid_next  = 1'b0;
        ready_next  = 1'b0;
        case (state)
            ST_INIT: begin
                state_next = ST_IDLE;
                ready_next = 1'b1;
            end
            ST_IDLE: begin
                ready_next = 1'b1;
                if (i_cmd != CMD_NOP) begin
                    op_next    = i_cmd;
                    acc_next   = load_acc;
                    cnt_next   = load_cnt;
                    ready_next = 1'b0;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt != '0) begin
                    acc_next = step;
                    cnt_next = cnt - CNT_ONE;
                end else begin
                    result_next = acc;
                    valid_next  = 1'b1;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                ready_next = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // FSM state register; reset always lands in INIT so ready rises afresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op       <= CMD_NOP;
            acc      <= '0;
            cnt      <= '0;
            o_result <= '0;
            o_valid  <= 1'b0;
            o_ready  <= 1'b0;
        end else begin
            op       <= op_next;
            acc      <= acc_next;
            cnt      <= cnt_next;
            o_result <= result_next;
            o_valid  <= valid_next;
            o_ready  <= ready_next;
        end
    end

endmodule

// File: tb/tb_alu_shift_unit.sv
// Testbench for alu_shift_unit: directed scenarios plus random SHL traffic,
// with a result/latency scoreboard fed at command issue.
module tb_alu_shift_unit;

    localparam int W = 32;

    localparam logic [3:0] NOP = 4'h0;
    localparam logic [3:0] SHL = 4'h1;
    localparam logic [3:0] SHR = 4'h2;
    localparam logic [3:0] SAR = 4'h3;
    localparam logic [3:0] ROL = 4'h4;
    localparam logic [3:0] ROR = 4'h5;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic [3:0]   i_cmd = NOP;
    logic [W-1:0] o_result;
    logic         o_valid;
    logic         o_ready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           acc_q[$];

    alu_shift_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_cmd    (i_cmd),
        .o_result (o_result),
        .o_valid  (o_valid),
        .o_ready  (o_ready)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!reset && o_valid) begin
            checks++;
            if (o_ready) begin
                errors++;
                $display("FAIL ready_with_valid: o_ready=%0b while o_valid, required 0", o_ready);
            end
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: o_result=%h with no command outstanding", o_result);
            end else begin
                logic [W-1:0] e;
                int lat;
                int c0;
                e   = exp_q.pop_front();
                lat = lat_q.pop_front();
                c0  = acc_q.pop_front();
                if (o_result !== e) begin
                    errors++;
                    $display("FAIL result: got %h, required %h", o_result, e);
                end
                checks++;
                if ((cyc - c0) !== lat) begin
                    errors++;
                    $display("FAIL latency: got %0d cycles, required %0d", cyc - c0, lat);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; waits for ready, presents the command for one edge.
    task automatic send(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int lat);
        int t;
        t = 0;
        while (!o_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: o_ready=%0b after %0d cycles, required 1", o_ready, t);
        end else begin
            i_a   = a;
            i_b   = b;
            i_cmd = cmd;
            exp_q.push_back(exp);
            lat_q.push_back(lat);
            acc_q.push_back(cyc + 1);
            @(negedge clk);
            i_cmd = NOP;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !o_ready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || !o_ready) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: %0d results pending, o_ready=%0b, required 0 pending and ready",
                     exp_q.size(), o_ready);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        i_cmd = NOP;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (o_ready !== 1'b0 || o_valid !== 1'b0 || o_result !== '0) begin
                errors++;
                $display("FAIL reset_hold: ready=%0b valid=%0b result=%h, required 0 0 0",
                         o_ready, o_valid, o_result);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL init_ready: o_ready=%0b, required 0", o_ready);
        end
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== '0) begin
            errors++;
            $display("FAIL ready_rise: ready=%0b valid=%0b result=%h, required 1 0 0",
                     o_ready, o_valid, o_result);
        end
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
                errors++;
                $display("FAIL nop_idle: ready=%0b valid=%0b, required 1 0", o_ready, o_valid);
            end
        end
    endtask

    task automatic test_shl_basic();
        int t;
        send(SHL, 32'h0000_00F1, 32'd4, 32'h0000_0F10, 5);
        t = 0;
        while (!o_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== 32'h0000_0F10) begin
            errors++;
            $display("FAIL shl_after: ready=%0b valid=%0b result=%h, required 1 0 00000f10",
                     o_ready, o_valid, o_result);
        end
        send(SHL, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
        wait_idle();
    endtask

    task automatic test_large_amounts();
        send(SHL, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        send(SHR, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        send(SAR, 32'h8000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        send(SAR, 32'h7000_0001, 32'h0000_0020, 32'h0000_0000, 1);
        send(ROL, 32'h8000_0001, 32'hFFFF_FFFF, 32'hC000_0000, 32);
        wait_idle();
    endtask

    task automatic test_right_rotate();
        send(SHR, 32'h8000_0010, 32'd4, 32'h0800_0001, 5);
        send(SAR, 32'h8000_0010, 32'd4, 32'hF800_0001, 5);
        send(ROR, 32'h0000_0001, 32'd1, 32'h8000_0000, 2);
        send(ROL, 32'h8000_0000, 32'd1, 32'h0000_0001, 2);
        send(ROR, 32'h0000_00FF, 32'd8, 32'hFF00_0000, 9);
        wait_idle();
    endtask

    task automatic test_stability();
        int t;
        logic [W-1:0] held;
        send(SHL, 32'h0000_00F1, 32'd4, 32'h0000_0F10, 5);
        wait_idle();
        held = 32'h0000_0F10;
        send(ROL, 32'h0000_00A5, 32'd12, 32'h000A_5000, 13);
        t = 0;
        while (!o_valid && t < 50) begin
            checks++;
            if (o_result !== held) begin
                errors++;
                $display("FAIL result_hold: got %h, required %h", o_result, held);
            end
            i_a   = $urandom;
            i_b   = $urandom;
            i_cmd = 4'($urandom_range(1, 15));
            @(negedge clk);
            t++;
        end
        // A command presented while DONE must be ignored.
        i_cmd = SHL;
        i_a   = 32'hFFFF_FFFF;
        i_b   = 32'd3;
        @(negedge clk);
        i_cmd = NOP;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_result !== 32'h000A_5000) begin
            errors++;
            $display("FAIL done_ignore: ready=%0b result=%h, required 1 000a5000", o_ready, o_result);
        end
        wait_idle();
    endtask

    task automatic test_random_shl();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e;
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = W'($urandom_range(0, 40));
            e = (b >= 32) ? '0 : (a << b[4:0]);
            send(SHL, a, b, e, (b >= 32) ? 1 : int'(b) + 1);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        send(SHL, 32'h0000_0003, 32'd20, 32'h0030_0000, 21);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b0 || o_valid !== 1'b0 || o_result !== '0) begin
            errors++;
            $display("FAIL mid_reset: ready=%0b valid=%0b result=%h, required 0 0 0",
                     o_ready, o_valid, o_result);
        end
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0 || o_result !== '0) begin
                errors++;
                $display("FAIL reset_no_valid: valid=%0b result=%h, required 0 0", o_valid, o_result);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        send(SHR, 32'hF000_0000, 32'd8, 32'h00F0_0000, 9);
        wait_idle();
    endtask

    task automatic test_unsupported();
        send(4'hF, 32'hDEAD_BEEF, 32'd3, 32'h0000_0000, 1);
        send(SHL, 32'h0000_0001, 32'd31, 32'h8000_0000, 32);
        send(4'h7, 32'h1234_5678, 32'd9, 32'h0000_0000, 1);
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_shl_basic();
        test_large_amounts();
        test_right_rotate();
        test_stability();
        test_random_shl();
        test_reset_mid();
        test_unsupported();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d results never produced, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
